otter_cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER RV32I core. It sequences the program-counter register, register file, memory and CSR block by emitting one-cycle write and read enables per state. It handles the fetch/execute/writeback cycle and machine-mode interrupt entry, and keeps a retired-instruction counter. It sits beside the decoder and drives the PC register's write and reset inputs directly.

---
 rtl/otter_pkg.sv | 31 +++
 rtl/otter_instret_counter.sv | 19 +
 rtl/otter_cu_fsm.sv | 116 +++++++++++
 tb/tb_otter_cu_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER multicycle control unit.
package otter_pkg;

    // Control-unit states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // SYSTEM-opcode FUNCT3 encodings that the control unit acts on
    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/otter_instret_counter.sv
// Retired-instruction counter: free-running, wraps at 2^W.
module otter_instret_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count one per enabled edge; natural overflow gives the wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER RV32I multicycle control unit: fetch/exec/writeback sequencing,
// machine-mode interrupt entry and retired-instruction counting.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNCT3,
    input  logic             INTR,
    input  logic             CSR_MIE,
    output logic             PC_WRITE,
    output logic             PC_RST,
    output logic             REG_WRITE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC,
    output logic [CNT_W-1:0] INSTRET
);

    state_t state, state_nxt;
    logic   irq_take;
    logic   retire;

    // Interrupt qualification uses MIE as currently held, so a CSR write
    // or mret in this same EXEC cycle cannot influence the decision.
    assign irq_take = INTR & CSR_MIE;

    // An instruction retires when leaving EXEC (non-load) or leaving WB
    assign retire = ((state == ST_EXEC) && (OPCODE != OP_LOAD)) ||
                    (state == ST_WB);

    // State register; reset parks in INIT so PC_RST is asserted throughout
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    // Next-state and per-state enables, all default low
    always_comb begin
        state_nxt = state;
        PC_WRITE  = 1'b0;
        PC_RST    = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        unique case (state)
            ST_INIT: begin
                PC_RST    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = irq_take ? ST_INTR : ST_FETCH;
                PC_WRITE  = 1'b1;
                case (OPCODE)
                    OP_LOAD: begin
                        // PC advances at WB, not here
                        PC_WRITE  = 1'b0;
                        MEM_RDEN2 = 1'b1;
                        state_nxt = ST_WB;
                    end
                    OP_STORE:  MEM_WE2 = 1'b1;
                    OP_BRANCH: ;
                    OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                        REG_WRITE = 1'b1;
                    OP_SYSTEM: begin
                        case (FUNCT3)
                            F3_MRET: MRET_EXEC = 1'b1;
                            F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                                CSR_WE    = 1'b1;
                                REG_WRITE = 1'b1;
                            end
                            default: ;  // other SYSTEM forms run as NOP
                        endcase
                    end
                    default: ;          // unknown opcode runs as NOP
                endcase
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                state_nxt = irq_take ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                // INTR is deliberately not re-sampled here
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    otter_instret_counter #(.W(CNT_W)) u_instret (
        .clk   (clk),
        .rst_n (RST_N),
        .en    (retire),
        .count (INSTRET)
    );

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed self-checking bench for otter_cu_fsm (32-bit and 4-bit counters).
module tb_otter_cu_fsm;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        INTR;
    logic        CSR_MIE;

    logic        pcw, pcr, rw, rd1, rd2, we2, csrwe, intt, mret;
    logic        pcw4, pcr4, rw4, rd14, rd24, we24, csrwe4, intt4, mret4;
    logic [31:0] instret;
    logic [3:0]  instret4;
    logic [8:0]  outs, outs4;

    int checks = 0;
    int passes = 0;

    // Output bundle order: PC_WRITE PC_RST REG_WRITE RDEN1 RDEN2 WE2 CSR_WE INT_TAKEN MRET
    localparam logic [8:0] E_INIT  = 9'b010000000;
    localparam logic [8:0] E_FETCH = 9'b000100000;
    localparam logic [8:0] E_ALU   = 9'b101000000;
    localparam logic [8:0] E_LOAD  = 9'b000010000;
    localparam logic [8:0] E_WB    = 9'b101000000;
    localparam logic [8:0] E_STORE = 9'b100001000;
    localparam logic [8:0] E_INTR  = 9'b100000010;
    localparam logic [8:0] E_MRET  = 9'b100000001;
    localparam logic [8:0] E_CSR   = 9'b101000100;
    localparam logic [8:0] E_NOP   = 9'b100000000;

    assign outs  = {pcw, pcr, rw, rd1, rd2, we2, csrwe, intt, mret};
    assign outs4 = {pcw4, pcr4, rw4, rd14, rd24, we24, csrwe4, intt4, mret4};

    always #5 clk = ~clk;

    otter_cu_fsm dut (
        .clk(clk), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
        .INTR(INTR), .CSR_MIE(CSR_MIE),
        .PC_WRITE(pcw), .PC_RST(pcr), .REG_WRITE(rw), .MEM_RDEN1(rd1),
        .MEM_RDEN2(rd2), .MEM_WE2(we2), .CSR_WE(csrwe), .INT_TAKEN(intt),
        .MRET_EXEC(mret), .INSTRET(instret)
    );

    otter_cu_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
        .INTR(INTR), .CSR_MIE(CSR_MIE),
        .PC_WRITE(pcw4), .PC_RST(pcr4), .REG_WRITE(rw4), .MEM_RDEN1(rd14),
        .MEM_RDEN2(rd24), .MEM_WE2(we24), .CSR_WE(csrwe4), .INT_TAKEN(intt4),
        .MRET_EXEC(mret4), .INSTRET(instret4)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; OPCODE = 7'd0; FUNCT3 = 3'd0; INTR = 1'b0; CSR_MIE = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs !== E_INIT || outs4 !== E_INIT)
                $display("FAIL reset_hold[%0d]: got %b/%b want %b", i, outs, outs4, E_INIT);
            else passes++;
        end
        checks++;
        if (instret !== 32'd0 || instret4 !== 4'd0)
            $display("FAIL reset_instret: got %0d/%0d want 0", instret, instret4);
        else passes++;
        RST_N = 1'b1;
        #1;
        checks++;
        if (outs !== E_INIT)
            $display("FAIL reset_first_edge: got %b want %b", outs, E_INIT);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH || outs4 !== E_FETCH)
            $display("FAIL reset_to_fetch: got %b/%b want %b", outs, outs4, E_FETCH);
        else passes++;
        checks++;
        if (instret !== 32'd0)
            $display("FAIL reset_fetch_instret: got %0d want 0", instret);
        else passes++;
    endtask

    task automatic test_opimm();
        OPCODE = 7'b0010011;
        step();
        checks++;
        if (outs !== E_ALU)
            $display("FAIL opimm_exec: got %b want %b", outs, E_ALU);
        else passes++;
        checks++;
        if (instret !== 32'd0)
            $display("FAIL opimm_instret_before: got %0d want 0", instret);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH)
            $display("FAIL opimm_back_fetch: got %b want %b", outs, E_FETCH);
        else passes++;
        checks++;
        if (instret !== 32'd1)
            $display("FAIL opimm_instret_after: got %0d want 1", instret);
        else passes++;
    endtask

    task automatic test_load();
        OPCODE = 7'b0000011;
        step();
        checks++;
        if (outs !== E_LOAD)
            $display("FAIL load_exec: got %b want %b", outs, E_LOAD);
        else passes++;
        step();
        checks++;
        if (outs !== E_WB)
            $display("FAIL load_wb: got %b want %b", outs, E_WB);
        else passes++;
        checks++;
        if (instret !== 32'd1)
            $display("FAIL load_instret_in_wb: got %0d want 1", instret);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH || instret !== 32'd2)
            $display("FAIL load_wb_exit: got %b/%0d want %b/2", outs, instret, E_FETCH);
        else passes++;
    endtask

    task automatic test_intr();
        // INTR held through FETCH must not divert the FSM there
        OPCODE = 7'b0100011; INTR = 1'b1; CSR_MIE = 1'b1;
        step();
        checks++;
        if (outs !== E_STORE)
            $display("FAIL intr_store_exec: got %b want %b", outs, E_STORE);
        else passes++;
        step();
        checks++;
        if (outs !== E_INTR)
            $display("FAIL intr_entry: got %b want %b", outs, E_INTR);
        else passes++;
        checks++;
        if (instret !== 32'd3)
            $display("FAIL intr_instret: got %0d want 3", instret);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH || instret !== 32'd3)
            $display("FAIL intr_exit: got %b/%0d want %b/3", outs, instret, E_FETCH);
        else passes++;
        CSR_MIE = 1'b0;
        step();
        checks++;
        if (outs !== E_STORE)
            $display("FAIL intr_masked_exec: got %b want %b", outs, E_STORE);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH || instret !== 32'd4)
            $display("FAIL intr_masked_fetch: got %b/%0d want %b/4", outs, instret, E_FETCH);
        else passes++;
        INTR = 1'b0;
    endtask

    task automatic test_system();
        OPCODE = 7'b1110011; FUNCT3 = 3'b000;
        step();
        checks++;
        if (outs !== E_MRET)
            $display("FAIL sys_mret: got %b want %b", outs, E_MRET);
        else passes++;
        step();
        FUNCT3 = 3'b010;
        step();
        checks++;
        if (outs !== E_CSR)
            $display("FAIL sys_csrrs: got %b want %b", outs, E_CSR);
        else passes++;
        step();
        FUNCT3 = 3'b100;
        step();
        checks++;
        if (outs !== E_NOP)
            $display("FAIL sys_nop: got %b want %b", outs, E_NOP);
        else passes++;
        step();
        checks++;
        if (outs !== E_FETCH || instret !== 32'd7)
            $display("FAIL sys_instret: got %b/%0d want %b/7", outs, instret, E_FETCH);
        else passes++;
        FUNCT3 = 3'b000;
    endtask

    task automatic test_wrap();
        OPCODE = 7'b0110011;
        for (int i = 0; i < 8; i++) begin
            step();
            step();
        end
        checks++;
        if (instret4 !== 4'd15 || instret !== 32'd15)
            $display("FAIL wrap_at_15: got %0d/%0d want 15/15", instret4, instret);
        else passes++;
        step();
        step();
        checks++;
        if (instret4 !== 4'd0 || instret !== 32'd16)
            $display("FAIL wrap_to_0: got %0d/%0d want 0/16", instret4, instret);
        else passes++;
    endtask

    task automatic test_async_reset();
        // Drop reset mid-EXEC, well before the next edge
        OPCODE = 7'b0010011;
        step();
        RST_N = 1'b0;
        #1;
        checks++;
        if (outs !== E_INIT || outs4 !== E_INIT)
            $display("FAIL areset_exec_outs: got %b/%b want %b", outs, outs4, E_INIT);
        else passes++;
        checks++;
        if (instret !== 32'd0 || instret4 !== 4'd0)
            $display("FAIL areset_exec_instret: got %0d/%0d want 0", instret, instret4);
        else passes++;
        step();
        RST_N = 1'b1;
        step();
        // Drop reset while in WB of a load
        OPCODE = 7'b0000011;
        step();
        step();
        checks++;
        if (outs !== E_WB)
            $display("FAIL areset_reach_wb: got %b want %b", outs, E_WB);
        else passes++;
        RST_N = 1'b0;
        #1;
        checks++;
        if (outs !== E_INIT || instret !== 32'd0)
            $display("FAIL areset_wb: got %b/%0d want %b/0", outs, instret, E_INIT);
        else passes++;
        RST_N = 1'b1;
        step();
        checks++;
        if (outs !== E_FETCH)
            $display("FAIL areset_recover: got %b want %b", outs, E_FETCH);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_load();
        test_intr();
        test_system();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
